// File: rtl/maxi_write_bridge.sv
// AXI3 write-master bridge: packed {valid,payload} address/data streams to MAXI AW/W/B.
// Optional B-response error tracking is built when MAXI_WRITE_BRIDGE_BRESP_CHECK_EN is defined.
module maxi_write_bridge #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     IP_CLK,
    input  logic                                     IP_ARESET_N,

    input  logic [ADDR_W:0]                          ADDR_IN,
    output logic                                     ADDR_IN_ready,
    input  logic [DATA_W:0]                          DATA_IN,
    output logic                                     DATA_IN_ready,

    output logic [ADDR_W-1:0]                        MAXI_AWADDR,
    output logic                                     MAXI_AWVALID,
    input  logic                                     MAXI_AWREADY,
    output logic [3:0]                               MAXI_AWLEN,
    output logic [1:0]                               MAXI_AWSIZE,
    output logic [1:0]                               MAXI_AWBURST,

    output logic [DATA_W-1:0]                        MAXI_WDATA,
    output logic                                     MAXI_WVALID,
    input  logic                                     MAXI_WREADY,
    output logic [DATA_W/8-1:0]                      MAXI_WSTRB,
    output logic                                     MAXI_WLAST,

    input  logic [1:0]                               MAXI_BRESP,
    input  logic                                     MAXI_BVALID,
    output logic                                     MAXI_BREADY,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     OUTSTANDING,
    output logic                                     IDLE,
    output logic                                     ERR
);

    localparam int unsigned OutW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [OutW-1:0]  MaxOut   = OutW'(MAX_OUTSTANDING);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

    // run_q keeps every ready low on the first cycle out of reset.
    logic              run_q;

    logic              aw_vld_q, aw_vld_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;

    logic              w_vld_q, w_vld_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              w_last_q, w_last_d;
    logic [BeatW-1:0]  beat_q, beat_d;

    logic [OutW-1:0]   out_q, out_d;
    logic [OutW-1:0]   credit_q, credit_d;

    logic              addr_valid;
    logic              addr_ready;
    logic              addr_fire;
    logic              aw_fire;
    logic              data_valid;
    logic              data_ready;
    logic              data_fire;
    logic              last_fire;
    logic              w_fire;
    logic              b_fire;
    logic              b_dec;

    assign addr_valid = ADDR_IN[ADDR_W];
    assign data_valid = DATA_IN[DATA_W];

    assign addr_ready = run_q && !aw_vld_q && (out_q < MaxOut);
    assign addr_fire  = addr_valid && addr_ready;
    assign aw_fire    = aw_vld_q && MAXI_AWREADY;

    // Credit counts bursts whose address is accepted but whose beats are not all taken yet.
    assign data_ready = (credit_q != '0) && (!w_vld_q || MAXI_WREADY);
    assign data_fire  = data_valid && data_ready;
    assign last_fire  = data_fire && (beat_q == LastBeat);
    assign w_fire     = w_vld_q && MAXI_WREADY;

    assign b_fire     = MAXI_BVALID && run_q;
    assign b_dec      = b_fire && (out_q != '0);

    always_comb begin
        aw_vld_d  = aw_vld_q;
        aw_addr_d = aw_addr_q;
        if (aw_fire) begin
            aw_vld_d = 1'b0;
        end
        if (addr_fire) begin
            aw_vld_d  = 1'b1;
            aw_addr_d = ADDR_IN[ADDR_W-1:0];
        end
    end

    always_comb begin
        w_vld_d  = w_vld_q;
        w_data_d = w_data_q;
        w_last_d = w_last_q;
        beat_d   = beat_q;
        if (data_fire) begin
            w_vld_d  = 1'b1;
            w_data_d = DATA_IN[DATA_W-1:0];
            w_last_d = (beat_q == LastBeat);
            beat_d   = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
        end else if (w_fire) begin
            w_vld_d  = 1'b0;
            w_last_d = 1'b0;
        end
    end

    always_comb begin
        out_d = out_q;
        unique case ({addr_fire, b_dec})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        unique case ({addr_fire, last_fire})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge IP_CLK) begin
        if (!IP_ARESET_N) begin
            run_q     <= 1'b0;
            aw_vld_q  <= 1'b0;
            aw_addr_q <= '0;
            w_vld_q   <= 1'b0;
            w_data_q  <= '0;
            w_last_q  <= 1'b0;
            beat_q    <= '0;
            out_q     <= '0;
            credit_q  <= '0;
        end else begin
            run_q     <= 1'b1;
            aw_vld_q  <= aw_vld_d;
            aw_addr_q <= aw_addr_d;
            w_vld_q   <= w_vld_d;
            w_data_q  <= w_data_d;
            w_last_q  <= w_last_d;
            beat_q    <= beat_d;
            out_q     <= out_d;
            credit_q  <= credit_d;
        end
    end

`ifdef MAXI_WRITE_BRIDGE_BRESP_CHECK_EN
    logic err_q, err_d;

    // A B response with nothing in flight is a protocol error from the slave.
    always_comb begin
        err_d = err_q;
        if (b_fire && ((MAXI_BRESP != 2'b00) || (out_q == '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge IP_CLK) begin
        if (!IP_ARESET_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^MAXI_BRESP;
    assign ERR          = 1'b0;
`endif

    assign ADDR_IN_ready = addr_ready;
    assign DATA_IN_ready = data_ready;

    assign MAXI_AWADDR  = aw_addr_q;
    assign MAXI_AWVALID = aw_vld_q;
    assign MAXI_AWLEN   = 4'(BURST_LEN - 1);
    assign MAXI_AWSIZE  = (DATA_W == 64) ? 2'd3 : 2'd2;
    assign MAXI_AWBURST = 2'b01;

    assign MAXI_WDATA  = w_data_q;
    assign MAXI_WVALID = w_vld_q;
    assign MAXI_WSTRB  = '1;
    assign MAXI_WLAST  = w_last_q;

    assign MAXI_BREADY = run_q;

    assign OUTSTANDING = out_q;
    assign IDLE        = (out_q == '0) && !aw_vld_q && !w_vld_q && (beat_q == '0);

endmodule
